// File: rtl/color_sequence_player_if.sv
// Handshake/bus bundle between the Simon game FSM and the color sequence player.
interface color_sequence_player_if;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned COLOR_W = 4;

  logic               Tick;
  logic               Wr_En;
  logic [IDX_W-1:0]   Wr_Idx;
  logic [CODE_W-1:0]  Wr_Color;
  logic [IDX_W-1:0]   Rd_Idx;
  logic [CODE_W-1:0]  Rd_Color;
  logic               Play_Req;
  logic [IDX_W-1:0]   Play_Len;
  logic               Abort;
  logic               Play_Busy;
  logic               Play_Done;
  logic [COLOR_W-1:0] gColor;
  logic [IDX_W-1:0]   Play_Idx;

  modport master (
    output Tick, Wr_En, Wr_Idx, Wr_Color, Rd_Idx, Play_Req, Play_Len, Abort,
    input  Rd_Color, Play_Busy, Play_Done, gColor, Play_Idx
  );

  modport slave (
    input  Tick, Wr_En, Wr_Idx, Wr_Color, Rd_Idx, Play_Req, Play_Len, Abort,
    output Rd_Color, Play_Busy, Play_Done, gColor, Play_Idx
  );
endinterface

// File: rtl/color_sequence_player.sv
// Simon color sequence memory and tick-paced playback scheduler.
// Plays the first Play_Len stored colors with ON/OFF intervals; exposes a compare read port.
module color_sequence_player #(
  parameter int unsigned MAX_LEN   = 10,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  color_sequence_player_if.slave  bus
);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned CNT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COLOR_W-1:0]   gcolor_q, gcolor_d;
  logic                 busy_q, done_q;
  logic [CODE_W-1:0]    mem_q [MAX_LEN];
  logic [CODE_W-1:0]    mem_d [MAX_LEN];

  // Compare read port: out-of-range indices read as blank.
  assign bus.Rd_Color  = (bus.Rd_Idx < MAX_IDX) ? mem_q[bus.Rd_Idx] : '0;
  assign bus.gColor    = gcolor_q;
  assign bus.Play_Busy = busy_q;
  assign bus.Play_Done = done_q;
  assign bus.Play_Idx  = idx_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gcolor_d = gcolor_q;
    mem_d    = mem_q;

    // Writes land before the first SHOW color is registered, so a same-cycle request sees them.
    if (bus.Wr_En && (bus.Wr_Idx < MAX_IDX) && (state_q == S_IDLE)) begin
      mem_d[bus.Wr_Idx] = bus.Wr_Color;
    end

    case (state_q)
      S_IDLE: begin
        gcolor_d = '0;
        idx_d    = '0;
        cnt_d    = '0;
        if (bus.Play_Req && !bus.Abort) begin
          len_d = (bus.Play_Len > MAX_IDX) ? MAX_IDX : bus.Play_Len;
          if (len_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SHOW;
            gcolor_d = COLOR_W'(mem_d[0]);
          end
        end
      end
      S_SHOW: begin
        if (bus.Tick) begin
          if (cnt_q == ON_LAST) begin
            state_d  = S_GAP;
            gcolor_d = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        gcolor_d = '0;
        if (bus.Tick) begin
          if (cnt_q == OFF_LAST) begin
            cnt_d = '0;
            if (idx_q == (len_q - IDX_W'(1))) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_SHOW;
              idx_d    = idx_q + IDX_W'(1);
              gcolor_d = COLOR_W'(mem_d[idx_q + IDX_W'(1)]);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        idx_d    = '0;
        gcolor_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        idx_d    = '0;
        cnt_d    = '0;
        gcolor_d = '0;
      end
    endcase

    // Abort beats ticks and the DONE transition; no completion pulse follows.
    if (bus.Abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      gcolor_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gcolor_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gcolor_q <= gcolor_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_color_sequence_player.sv
// Scoreboard bench for color_sequence_player: expected per-cycle display is queued at request time.
module tb_color_sequence_player;
  localparam int MAX_LEN   = 10;
  localparam int ON_TICKS  = 4;
  localparam int OFF_TICKS = 2;
  localparam int SLOT      = ON_TICKS + OFF_TICKS;

  typedef struct packed {
    logic [3:0] g;
    logic       busy;
    logic       done;
    logic [3:0] idx;
    logic       chk_idx;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n;
  int   errors;
  int   checks;
  int   tick_n;
  int   tick_period;
  exp_t sb[$];
  logic [2:0] model_mem [MAX_LEN];

  color_sequence_player_if ifc ();

  color_sequence_player #(.MAX_LEN(MAX_LEN), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifc)
  );

  always #5 Clk = ~Clk;

  task automatic next_edge();
    @(posedge Clk);
    #1;
    tick_n++;
    ifc.Tick = ((tick_n % tick_period) == 0);
  endtask

  task automatic write_mem(input logic [3:0] idx, input logic [2:0] color);
    ifc.Wr_En    = 1'b1;
    ifc.Wr_Idx   = idx;
    ifc.Wr_Color = color;
    next_edge();
    ifc.Wr_En = 1'b0;
    if (int'(idx) < MAX_LEN) model_mem[idx] = color;
  endtask

  // Expected display timeline: ticks land on edges that are multiples of p, edge 0 samples Play_Req.
  task automatic push_play(input int len, input int p, input int abort_at);
    int eff, dk, n, t, slot, pos;
    exp_t e;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    dk  = eff * SLOT * p;
    n   = (abort_at >= 0) ? abort_at + 3 : dk + 2;
    for (int k = 0; k < n; k++) begin
      e = '0;
      if (abort_at >= 0 && k >= abort_at) begin
        e.chk_idx = 1'b1;
      end else if (k < dk) begin
        t    = k / p;
        slot = t / SLOT;
        pos  = t % SLOT;
        e.g       = (pos < ON_TICKS) ? {1'b0, model_mem[slot]} : 4'd0;
        e.busy    = 1'b1;
        e.idx     = 4'(slot);
        e.chk_idx = 1'b1;
      end else if (k == dk) begin
        e.busy = 1'b1;
        e.done = 1'b1;
      end else begin
        e.chk_idx = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_play(input int len, input int p);
    tick_period  = p;
    tick_n       = 0;
    ifc.Play_Len = 4'(len);
    ifc.Play_Req = 1'b1;
    ifc.Tick     = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] rd;
    Reset_n = 1'b0;
    ifc.Tick = 1'b0; ifc.Wr_En = 1'b0; ifc.Wr_Idx = '0; ifc.Wr_Color = '0;
    ifc.Rd_Idx = '0; ifc.Play_Req = 1'b0; ifc.Play_Len = '0; ifc.Abort = 1'b0;
    tick_period = 1; tick_n = 0;
    for (int i = 0; i < MAX_LEN; i++) model_mem[i] = '0;
    #23 Reset_n = 1'b1;
    next_edge();
    checks++;
    if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done, ifc.Play_Idx} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got g=%0d busy=%0b done=%0b idx=%0d required all 0",
               ifc.gColor, ifc.Play_Busy, ifc.Play_Done, ifc.Play_Idx);
    end
    for (int i = 0; i < 16; i++) begin
      ifc.Rd_Idx = 4'(i);
      #1;
      rd = ifc.Rd_Color;
      checks++;
      if (rd !== 3'd0) begin
        errors++;
        $display("FAIL reset_mem idx=%0d got %0d required 0", i, rd);
      end
    end
    next_edge();
  endtask

  task automatic test_write_read();
    logic [2:0] exp;
    write_mem(4'd0, 3'd1);
    write_mem(4'd1, 3'd4);
    write_mem(4'd2, 3'd3);
    write_mem(4'd3, 3'd7);
    write_mem(4'd9, 3'd5);
    write_mem(4'd12, 3'd6);
    for (int i = 0; i < 16; i++) begin
      ifc.Rd_Idx = 4'(i);
      #1;
      exp = '0;
      if (i < MAX_LEN) exp = model_mem[i];
      checks++;
      if (ifc.Rd_Color !== exp) begin
        errors++;
        $display("FAIL write_read idx=%0d got %0d required %0d", i, ifc.Rd_Color, exp);
      end
    end
    next_edge();
  endtask

  task automatic test_basic_play();
    exp_t e;
    push_play(3, 1, -1);
    start_play(3, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL basic k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
      if (e.chk_idx) begin
        checks++;
        if (ifc.Play_Idx !== e.idx) begin
          errors++;
          $display("FAIL basic_idx k=%0d got %0d required %0d", k, ifc.Play_Idx, e.idx);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    exp_t e;
    push_play(0, 1, -1);
    start_play(0, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL len_zero k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
    end
  endtask

  task automatic test_len_clamp();
    exp_t e;
    for (int i = 0; i < MAX_LEN; i++) write_mem(4'(i), 3'((i % 4) + 1));
    push_play(15, 1, -1);
    start_play(15, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL clamp k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
      if (e.chk_idx) begin
        checks++;
        if (ifc.Play_Idx !== e.idx) begin
          errors++;
          $display("FAIL clamp_idx k=%0d got %0d required %0d", k, ifc.Play_Idx, e.idx);
        end
      end
    end
  endtask

  task automatic test_slow_tick();
    exp_t e;
    write_mem(4'd0, 3'd2);
    push_play(1, 3, -1);
    start_play(1, 3);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL slow_tick k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
    end
    tick_period = 1;
  endtask

  task automatic test_abort();
    exp_t e;
    write_mem(4'd0, 3'd1);
    write_mem(4'd1, 3'd4);
    write_mem(4'd2, 3'd3);
    // Abort lands on edge 7, inside the second SHOW interval.
    push_play(3, 1, 7);
    push_play(3, 1, -1);
    start_play(3, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      if (k == 6) ifc.Abort = 1'b1;
      if (k == 7) ifc.Abort = 1'b0;
      if (k == 9) start_play(3, 1);
      if (k == 10) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL abort k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
      if (e.chk_idx) begin
        checks++;
        if (ifc.Play_Idx !== e.idx) begin
          errors++;
          $display("FAIL abort_idx k=%0d got %0d required %0d", k, ifc.Play_Idx, e.idx);
        end
      end
    end
  endtask

  task automatic test_write_during_play();
    exp_t e;
    write_mem(4'd1, 3'd2);
    push_play(3, 1, -1);
    start_play(3, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
      if (k == 2) begin ifc.Wr_En = 1'b1; ifc.Wr_Idx = 4'd1; ifc.Wr_Color = 3'd4; end
      if (k == 3) ifc.Wr_En = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL frozen k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
    end
    ifc.Rd_Idx = 4'd1;
    #1;
    checks++;
    if (ifc.Rd_Color !== model_mem[1]) begin
      errors++;
      $display("FAIL frozen_rd got %0d required %0d", ifc.Rd_Color, model_mem[1]);
    end
  endtask

  task automatic test_write_with_req();
    exp_t e;
    ifc.Wr_En = 1'b1; ifc.Wr_Idx = 4'd0; ifc.Wr_Color = 3'd6;
    model_mem[0] = 3'd6;
    push_play(1, 1, -1);
    start_play(1, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 0) begin ifc.Play_Req = 1'b0; ifc.Wr_En = 1'b0; end
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL wr_with_req k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Request held through DONE restarts only from IDLE, one cycle after the pulse.
    push_play(1, 1, -1);
    push_play(1, 1, -1);
    start_play(1, 1);
    for (int k = 0; sb.size() > 0; k++) begin
      next_edge();
      if (k == 8) ifc.Play_Req = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== {e.g, e.busy, e.done}) begin
        errors++;
        $display("FAIL back_to_back k=%0d g/busy/done got %0d/%0b/%0b required %0d/%0b/%0b",
                 k, ifc.gColor, ifc.Play_Busy, ifc.Play_Done, e.g, e.busy, e.done);
      end
    end
  endtask

  task automatic test_async_reset();
    write_mem(4'd0, 3'd3);
    start_play(3, 1);
    for (int k = 0; k < 5; k++) begin
      next_edge();
      if (k == 0) ifc.Play_Req = 1'b0;
    end
    #3 Reset_n = 1'b0;
    #1;
    checks++;
    if ({ifc.gColor, ifc.Play_Busy, ifc.Play_Done} !== 6'd0) begin
      errors++;
      $display("FAIL async_reset got g=%0d busy=%0b done=%0b required 0/0/0",
               ifc.gColor, ifc.Play_Busy, ifc.Play_Done);
    end
    for (int i = 0; i < MAX_LEN; i++) model_mem[i] = '0;
    #2 Reset_n = 1'b1;
    next_edge();
    checks++;
    if ({ifc.Play_Busy, ifc.Play_Done} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_after got busy=%0b done=%0b required 0/0", ifc.Play_Busy, ifc.Play_Done);
    end
    for (int i = 0; i < 16; i++) begin
      ifc.Rd_Idx = 4'(i);
      #1;
      checks++;
      if (ifc.Rd_Color !== 3'd0) begin
        errors++;
        $display("FAIL async_reset_mem idx=%0d got %0d required 0", i, ifc.Rd_Color);
      end
    end
    next_edge();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_basic_play();
    test_len_zero();
    test_len_clamp();
    test_slow_tick();
    test_abort();
    test_write_during_play();
    test_write_with_req();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
